// File: rtl/chiplet_test_pkg.sv
// Shared constants for the chiplet testbench memory path.
package chiplet_test_pkg;

    localparam int unsigned HBMLatency = 100;

endpackage

// File: rtl/hbm_latency_buffer.sv
// Fixed-latency, in-order delay stage modelling HBM response latency.
// Each entry stores its enqueue timestamp and a sticky ripe flag.
module hbm_latency_buffer
    import chiplet_test_pkg::*;
#(
    parameter int unsigned Latency   = HBMLatency,
    parameter int unsigned Depth     = 128,
    parameter int unsigned DataWidth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DataWidth-1:0]       in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    // One extra timestamp bit guarantees the age compare hits exactly once before wrap.
    localparam int unsigned TsW  = $clog2(Latency) + 1;
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [TsW-1:0]  MatureAge = TsW'(Latency - 1);
    localparam logic [PtrW-1:0] LastIdx   = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] Full      = CntW'(Depth);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [TsW-1:0]       ts;
    } entry_t;

    entry_t           mem_q [Depth];
    logic [TsW-1:0]   now_q;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [Depth-1:0] ripe_q, ripe_d;
    logic [Depth-1:0] occ_q, occ_d;
    logic [Depth-1:0] mature;
    logic             enq;
    logic             deq;

    assign in_ready_o  = (count_q != Full);
    assign out_valid_o = (count_q != '0) && ripe_q[rptr_q];
    assign out_data_o  = mem_q[rptr_q].data;
    assign count_o     = count_q;
    assign enq         = in_valid_i && in_ready_o;
    assign deq         = out_valid_o && out_ready_i;

    for (genvar g = 0; g < Depth; g++) begin : g_mature
        assign mature[g] = occ_q[g] && !ripe_q[g]
                           && (TsW'(now_q - mem_q[g].ts) == MatureAge);
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ripe_d  = ripe_q | mature;
        occ_d   = occ_q;
        if (deq) begin
            ripe_d[rptr_q] = 1'b0;
            occ_d[rptr_q]  = 1'b0;
            rptr_d         = (rptr_q == LastIdx) ? '0 : rptr_q + 1'b1;
        end
        if (enq) begin
            ripe_d[wptr_q] = (Latency == 1);
            occ_d[wptr_q]  = 1'b1;
            wptr_d         = (wptr_q == LastIdx) ? '0 : wptr_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            now_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ripe_q  <= '0;
            occ_q   <= '0;
        end else begin
            now_q   <= now_q + 1'b1;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ripe_q  <= ripe_d;
            occ_q   <= occ_d;
        end
    end

    // Payload storage needs no reset; occupancy and ripe bits gate its use.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= '{data: in_data_i, ts: now_q};
        end
    end

`ifndef SYNTHESIS
    logic hold_q;

    always_ff @(posedge clk_i) begin
        hold_q <= !rst_i && out_valid_o && !out_ready_i;
        if (!rst_i) begin
            assert (Latency >= 1 && Depth >= 1);
            assert (count_q <= Full);
            if (hold_q) begin
                assert (out_valid_o);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hbm_latency_buffer.sv
// Directed bench for hbm_latency_buffer across four latency/depth configurations.
module tb_hbm_latency_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // A: Latency 100, Depth 128
    logic a_iv, a_ir, a_ov, a_or;
    logic [63:0] a_id, a_od;
    logic [7:0]  a_cnt;
    // B: Latency 4, Depth 2
    logic b_iv, b_ir, b_ov, b_or;
    logic [63:0] b_id, b_od;
    logic [1:0]  b_cnt;
    // C: Latency 8, Depth 8
    logic c_iv, c_ir, c_ov, c_or;
    logic [63:0] c_id, c_od;
    logic [3:0]  c_cnt;
    // D: Latency 1, Depth 1
    logic d_iv, d_ir, d_ov, d_or;
    logic [63:0] d_id, d_od;
    logic [0:0]  d_cnt;

    logic [63:0] exp_q[$];

    hbm_latency_buffer #(.Latency(100), .Depth(128), .DataWidth(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .count_o(a_cnt));
    hbm_latency_buffer #(.Latency(4), .Depth(2), .DataWidth(64)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .count_o(b_cnt));
    hbm_latency_buffer #(.Latency(8), .Depth(8), .DataWidth(64)) dut_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(c_iv), .in_ready_o(c_ir), .in_data_i(c_id),
        .out_valid_o(c_ov), .out_ready_i(c_or), .out_data_o(c_od), .count_o(c_cnt));
    hbm_latency_buffer #(.Latency(1), .Depth(1), .DataWidth(64)) dut_d (
        .clk_i(clk), .rst_i(rst), .in_valid_i(d_iv), .in_ready_o(d_ir), .in_data_i(d_id),
        .out_valid_o(d_ov), .out_ready_i(d_or), .out_data_o(d_od), .count_o(d_cnt));

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b want 0", a_ov); end
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b want 1", a_ir); end
        checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_a_count got %0d want 0", a_cnt); end
        checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b want 0", b_ov); end
        checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b want 1", b_ir); end
        checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL reset_b_count got %0d want 0", b_cnt); end
        checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL reset_c_valid got %b want 0", c_ov); end
        checks++; if (c_ir !== 1'b1) begin errors++; $display("FAIL reset_c_ready got %b want 1", c_ir); end
        checks++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL reset_c_count got %0d want 0", c_cnt); end
        checks++; if (d_ov !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b want 0", d_ov); end
        checks++; if (d_ir !== 1'b1) begin errors++; $display("FAIL reset_d_ready got %b want 1", d_ir); end
        checks++; if (d_cnt !== 1'd0) begin errors++; $display("FAIL reset_d_count got %0d want 0", d_cnt); end
    endtask

    // Item accepted in cycle 10 must first show valid in cycle 110.
    task automatic test_single_latency();
        for (int c = 0; c <= 112; c++) begin
            @(negedge clk);
            if (c > 10 && c < 110) begin
                checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL single_early cyc %0d got %b want 0", c, a_ov); end
            end
            if (c == 110) begin
                checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", a_ov); end
                checks++; if (a_od !== 64'hA5) begin errors++; $display("FAIL single_data got %0h want a5", a_od); end
                checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", a_cnt); end
            end
            if (c == 111) begin
                checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", a_ov); end
                checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL single_count_end got %0d want 0", a_cnt); end
            end
            a_iv = (c == 10);
            a_id = 64'hA5;
            a_or = (c == 110);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_d;
        int enq_n, deq_n;
        for (int c = 0; c <= 305; c++) begin
            @(negedge clk);
            enq_n = (c < 200) ? c : 200;
            deq_n = (c <= 100) ? 0 : ((c - 100 > 200) ? 200 : c - 100);
            exp_d = 64'hB2B0_0000_0000_0000 + 64'(c - 100);
            checks++; if (a_cnt !== 8'(enq_n - deq_n)) begin errors++; $display("FAIL b2b_count cyc %0d got %0d want %0d", c, a_cnt, enq_n - deq_n); end
            checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want 1", c, a_ir); end
            if (c >= 100 && c < 300) begin
                checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc %0d got %b want 1", c, a_ov); end
                checks++; if (a_od !== exp_d) begin errors++; $display("FAIL b2b_data cyc %0d got %0h want %0h", c, a_od, exp_d); end
            end else begin
                checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL b2b_idle cyc %0d got %b want 0", c, a_ov); end
            end
            a_or = 1'b1;
            a_iv = (c < 200);
            a_id = 64'hB2B0_0000_0000_0000 + 64'(c);
        end
        a_iv = 1'b0;
        a_or = 1'b0;
    endtask

    task automatic test_full_backpressure();
        int sent, recv;
        logic [63:0] exp_d;
        sent = 0;
        recv = 0;
        exp_q.delete();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++; if (b_ir !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", b_ir); end
                checks++; if (b_cnt !== 2'd2) begin errors++; $display("FAIL full_count got %0d want 2", b_cnt); end
            end
            if (c == 3) begin
                checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", b_ov); end
            end
            if (c == 4) begin
                checks++; if (b_ov !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", b_ov); end
                checks++; if (b_od !== 64'hD000) begin errors++; $display("FAIL full_data got %0h want d000", b_od); end
                checks++; if (b_ir !== 1'b0) begin errors++; $display("FAIL full_blocked got %b want 0", b_ir); end
            end
            if (c == 5) begin
                checks++; if (b_cnt !== 2'd1) begin errors++; $display("FAIL full_simul_count got %0d want 1", b_cnt); end
            end
            b_or = (c >= 4);
            if (b_ov && b_or) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                checks++; if (b_od !== exp_d) begin errors++; $display("FAIL full_order got %0h want %0h", b_od, exp_d); end
                recv++;
            end
            b_iv = (sent < 6);
            b_id = 64'hD000 + 64'(sent);
            if (b_iv && b_ir) begin
                exp_q.push_back(b_id);
                sent++;
            end
        end
        b_iv = 1'b0;
        b_or = 1'b0;
        checks++; if (recv !== 6) begin errors++; $display("FAIL full_lost got %0d want 6", recv); end
    endtask

    task automatic test_long_stall();
        logic [63:0] exp_d;
        for (int c = 0; c <= 1006; c++) begin
            @(negedge clk);
            if (c == 7) begin
                checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", c_ov); end
            end
            if (c == 8 || c == 500) begin
                checks++; if (c_ov !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", c, c_ov); end
                checks++; if (c_cnt !== 4'd5) begin errors++; $display("FAIL stall_count cyc %0d got %0d want 5", c, c_cnt); end
            end
            if (c >= 1000 && c <= 1004) begin
                exp_d = 64'hE00 + 64'(c - 1000);
                checks++; if (c_ov !== 1'b1) begin errors++; $display("FAIL stall_release_valid cyc %0d got %b want 1", c, c_ov); end
                checks++; if (c_od !== exp_d) begin errors++; $display("FAIL stall_release_data cyc %0d got %0h want %0h", c, c_od, exp_d); end
            end
            if (c == 1005) begin
                checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", c_ov); end
                checks++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL stall_count_end got %0d want 0", c_cnt); end
            end
            c_iv = (c < 5);
            c_id = 64'hE00 + 64'(c);
            c_or = (c >= 1000);
        end
        c_iv = 1'b0;
        c_or = 1'b0;
    endtask

    // Depth 1 with no same-cycle enqueue on dequeue: one item every two cycles.
    task automatic test_latency_one();
        logic odd;
        logic [63:0] exp_d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            odd   = c[0];
            exp_d = 64'h1000 + 64'((c - 1) / 2);
            checks++; if (d_ov !== odd) begin errors++; $display("FAIL lat1_valid cyc %0d got %b want %b", c, d_ov, odd); end
            checks++; if (d_ir !== !odd) begin errors++; $display("FAIL lat1_ready cyc %0d got %b want %b", c, d_ir, !odd); end
            checks++; if (d_cnt !== odd) begin errors++; $display("FAIL lat1_count cyc %0d got %0d want %0d", c, d_cnt, odd); end
            if (odd) begin
                checks++; if (d_od !== exp_d) begin errors++; $display("FAIL lat1_data cyc %0d got %0h want %0h", c, d_od, exp_d); end
            end
            d_iv = 1'b1;
            d_or = 1'b1;
            d_id = 64'h1000 + 64'(c / 2);
        end
        d_iv = 1'b0;
        d_or = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 120; c++) begin
            @(negedge clk);
            if (c == 120) begin
                checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", a_ov); end
                checks++; if (a_cnt !== 8'd50) begin errors++; $display("FAIL rst_pre_count got %0d want 50", a_cnt); end
            end
            a_iv = (c < 50);
            a_id = 64'hC000 + 64'(c);
            a_or = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", a_cnt); end
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", a_ov); end
        checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", a_ir); end
        a_or = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_stale cyc %0d got %b want 0", c, a_ov); end
        end
        for (int c = 0; c <= 101; c++) begin
            @(negedge clk);
            if (c == 99) begin
                checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL rst_fresh_early got %b want 0", a_ov); end
            end
            if (c == 100) begin
                checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL rst_fresh_valid got %b want 1", a_ov); end
                checks++; if (a_od !== 64'hF00D) begin errors++; $display("FAIL rst_fresh_data got %0h want f00d", a_od); end
            end
            if (c == 101) begin
                checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rst_fresh_count got %0d want 0", a_cnt); end
            end
            a_iv = (c == 0);
            a_id = 64'hF00D;
        end
        a_iv = 1'b0;
        a_or = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a_iv = 1'b0; a_or = 1'b0; a_id = '0;
        b_iv = 1'b0; b_or = 1'b0; b_id = '0;
        c_iv = 1'b0; c_or = 1'b0; c_id = '0;
        d_iv = 1'b0; d_or = 1'b0; d_id = '0;
        test_reset();
        test_single_latency();
        test_back_to_back();
        test_full_backpressure();
        test_long_stall();
        test_latency_one();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
